// File: rtl/sq_distance_pipe_nd.sv
// sq_distance_pipe_nd
//   Fully pipelined DIM-dimensional distance engine. Each accepted beat carries
//   a query point, a vertex point, a metric select and an opaque tag. The result
//   is the squared-Euclidean (metric_sel_in=0) or Manhattan (metric_sel_in=1)
//   distance, computed exactly in signed fixed point. Stages: S1 register,
//   S2 per-lane difference, S3 per-lane square/abs, then LVL registered levels
//   of a zero-padded pairwise adder tree. All stages advance together under a
//   single global stall (adv) derived from the output handshake.
// Ports
//   clk_in, rst        : clock (rising edge), synchronous active-high reset
//   in_valid/in_ready  : input handshake, in_ready = !out_valid || out_ready
//   query_pos_in       : DIM signed coords, dim i at [i*WIDTH +: WIDTH]
//   vertex_pos_in      : DIM signed coords, same packing
//   metric_sel_in      : 0 = squared L2, 1 = L1
//   id_in              : tag returned with the result
//   out_valid/out_ready: output handshake
//   distance_out       : unsigned exact distance, OUT_W bits
//   id_out, metric_out : tag and metric select of the beat on distance_out
//   inflight_out       : number of occupied pipeline stages
module sq_distance_pipe_nd #(
  parameter int DIM   = 4,
  parameter int WIDTH = 16,
  parameter int ID_W  = 8,
  localparam int LVL   = (DIM > 1) ? $clog2(DIM) : 0,
  localparam int OUT_W = 2*WIDTH + 1 + LVL,
  localparam int LAT   = 3 + LVL,
  localparam int CNT_W = $clog2(LAT+1)
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] query_pos_in,
  input  logic [DIM*WIDTH-1:0] vertex_pos_in,
  input  logic                 metric_sel_in,
  input  logic [ID_W-1:0]      id_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     distance_out,
  output logic [ID_W-1:0]      id_out,
  output logic                 metric_out,
  output logic [CNT_W-1:0]     inflight_out
);

  localparam int NP = 1 << LVL;

  logic                    adv;
  logic                    accept;
  logic [NP*WIDTH-1:0]     qpad;
  logic [NP*WIDTH-1:0]     vpad;
  logic [LAT-1:0]          vld_q;
  logic [LAT-1:0]          met_q;
  logic [ID_W-1:0]         id_q  [LAT];
  logic signed [WIDTH-1:0] q1_q  [NP];
  logic signed [WIDTH-1:0] v1_q  [NP];
  logic signed [WIDTH:0]   d2_q  [NP];
  // tr_q[0] is the S3 term register; tr_q[l] for l>=1 is tree level l.
  // Lanes past the live width of a level are held at zero.
  logic [OUT_W-1:0]        tr_q  [LVL+1][NP];

  assign out_valid = vld_q[LAT-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv;

  // Pad inputs to a power-of-two lane count; padded lanes are constant zero.
  assign qpad = (NP*WIDTH)'(query_pos_in);
  assign vpad = (NP*WIDTH)'(vertex_pos_in);

  // Per-lane term: d*d fits in 2*WIDTH+1 unsigned bits (max 2^(2*WIDTH)).
  function automatic logic [OUT_W-1:0] lane_term(input logic signed [WIDTH:0] d,
                                                 input logic l1);
    logic signed [2*WIDTH+1:0] d_ext;
    logic signed [2*WIDTH+1:0] prod;
    logic [WIDTH:0]            mag;
    d_ext = (2*WIDTH+2)'(d);
    prod  = d_ext * d_ext;
    mag   = d[WIDTH] ? $unsigned(-d) : $unsigned(d);
    return l1 ? OUT_W'(mag) : OUT_W'(prod[2*WIDTH:0]);
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst) begin
      vld_q <= '0;
      met_q <= '0;
      for (int unsigned s = 0; s < LAT; s++) id_q[s] <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        q1_q[i] <= '0;
        v1_q[i] <= '0;
        d2_q[i] <= '0;
      end
      for (int unsigned l = 0; l <= LVL; l++)
        for (int unsigned j = 0; j < NP; j++) tr_q[l][j] <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[LAT-2:0], accept};
      met_q <= {met_q[LAT-2:0], accept ? metric_sel_in : met_q[0]};
      // Stage-1 data only loads on an accepted beat so idle-bus X never enters.
      if (accept) begin
        id_q[0] <= id_in;
        for (int unsigned i = 0; i < NP; i++) begin
          q1_q[i] <= $signed(qpad[i*WIDTH +: WIDTH]);
          v1_q[i] <= $signed(vpad[i*WIDTH +: WIDTH]);
        end
      end
      for (int unsigned s = 1; s < LAT; s++) id_q[s] <= id_q[s-1];
      for (int unsigned i = 0; i < NP; i++) begin
        d2_q[i]    <= $signed({q1_q[i][WIDTH-1], q1_q[i]}) -
                      $signed({v1_q[i][WIDTH-1], v1_q[i]});
        tr_q[0][i] <= lane_term(d2_q[i], met_q[1]);
      end
      for (int unsigned l = 1; l <= LVL; l++)
        for (int unsigned j = 0; j < NP; j++)
          if (j < (NP >> l)) tr_q[l][j] <= tr_q[l-1][2*j] + tr_q[l-1][2*j+1];
          else               tr_q[l][j] <= '0;
    end
  end

  assign distance_out = tr_q[LVL][0];
  assign id_out       = id_q[LAT-1];
  assign metric_out   = met_q[LAT-1];

  always_comb begin
    inflight_out = '0;
    for (int unsigned s = 0; s < LAT; s++)
      if (vld_q[s]) inflight_out = inflight_out + CNT_W'(1);
  end

endmodule
